// File: rtl/quad_result_accumulator_pkg.sv
// Shared types and arithmetic for the quadrature result accumulator.
// Define QUAD_ACC_SAT_EN to saturate accumulators instead of wrapping.
package procesador_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        EMIT
    } state_t;

    localparam int DRAIN_CYCLES = 2;
    localparam int WORD_W       = 32;

    typedef struct packed {
        logic [63:0] sum;
        logic        ovf;
    } add_t;

    // Operands arrive sign-extended from w bits to 64; so does the sum.
    function automatic add_t acc_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        add_t              r;
        logic signed [63:0] s;
`ifdef QUAD_ACC_SAT_EN
        logic signed [63:0] max_v;
`endif
        s = a + b;
        s = (s <<< (64 - w)) >>> (64 - w);
        r.ovf = (a[63] == b[63]) && (s[63] != a[63]);
`ifdef QUAD_ACC_SAT_EN
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (r.ovf) begin
            s = a[63] ? ~max_v : max_v;
        end
`endif
        r.sum = s;
        return r;
    endfunction

endpackage

// File: rtl/quad_result_accumulator_if.sv
// Control, sample stream and result stream of the quadrature accumulator.
// The design drives the slave side; the sample source uses master.
interface quad_result_accumulator_if #(
    parameter int SAMPLE_W = 16,
    parameter int REF_W    = 16,
    parameter int CNT_W    = 32
);
    logic                       start;
    logic [CNT_W-1:0]           n_samples;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample;
    logic signed [REF_W-1:0]    ref_cos;
    logic signed [REF_W-1:0]    ref_sin;
    logic                       busy;
    logic [31:0]                phase_low_data;
    logic [31:0]                phase_high_data;
    logic [31:0]                quad_low_data;
    logic [31:0]                quad_high_data;
    logic                       result_valid;
    logic                       overflow;

    modport master (
        output start, n_samples, sample_valid,
        output sample, ref_cos, ref_sin,
        input  busy, result_valid, overflow,
        input  phase_low_data, phase_high_data,
        input  quad_low_data, quad_high_data
    );

    modport slave (
        input  start, n_samples, sample_valid,
        input  sample, ref_cos, ref_sin,
        output busy, result_valid, overflow,
        output phase_low_data, phase_high_data,
        output quad_low_data, quad_high_data
    );
endinterface

// File: rtl/quad_result_accumulator_mac_lane.sv
// One multiply-accumulate lane: register, multiply, accumulate.
// Saturation vs wrap is selected by QUAD_ACC_SAT_EN in the package helper.
module quad_mac_lane
    import procesador_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int REF_W    = 16,
    parameter int ACC_W    = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic signed [REF_W-1:0]    ref_val,
    output logic signed [63:0]         acc,
    output logic                       ovf
);
    localparam int PROD_W = SAMPLE_W + REF_W;

    logic signed [SAMPLE_W-1:0] s_r;
    logic signed [REF_W-1:0]    r_r;
    logic signed [PROD_W-1:0]   prod;
    logic                       v1;
    logic                       v2;
    add_t                       nxt;

    always_comb nxt = acc_add(acc, 64'(prod), ACC_W);

    // acc is kept sign-extended to 64 bits so the output split is trivial
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_r  <= '0;
            r_r  <= '0;
            prod <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            acc  <= '0;
            ovf  <= 1'b0;
        end else if (clr) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                s_r <= sample;
                r_r <= ref_val;
            end
            v2 <= v1;
            if (v1) begin
                prod <= s_r * r_r;
            end
            if (v2) begin
                acc <= nxt.sum;
                ovf <= ovf | nxt.ovf;
            end
        end
    end

endmodule

// File: rtl/quad_result_accumulator.sv
// Lock-in demodulator: accumulates sample*cos and sample*sin per run.
// Build with QUAD_ACC_SAT_EN for saturating accumulators.
module quad_result_accumulator
    import procesador_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int REF_W    = 16,
    parameter int ACC_W    = 64,
    parameter int CNT_W    = 32
) (
    input logic                      clock,
    input logic                      reset,
    quad_result_accumulator_if.slave bus
);
    state_t            state;
    logic [CNT_W-1:0]  n_lat;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        dcnt;
    logic              busy_r;
    logic              rv_r;
    logic [WORD_W-1:0] pl_r;
    logic [WORD_W-1:0] ph_r;
    logic [WORD_W-1:0] ql_r;
    logic [WORD_W-1:0] qh_r;
    logic signed [63:0] phase_acc;
    logic signed [63:0] quad_acc;
    logic              phase_ovf;
    logic              quad_ovf;
    logic              accept;
    logic              clr;

    assign accept = (state == RUN) && bus.sample_valid;
    assign clr    = (state == IDLE) && bus.start;

    quad_mac_lane #(
        .SAMPLE_W(SAMPLE_W),
        .REF_W   (REF_W),
        .ACC_W   (ACC_W)
    ) u_phase (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr),
        .in_valid(accept),
        .sample  (bus.sample),
        .ref_val (bus.ref_cos),
        .acc     (phase_acc),
        .ovf     (phase_ovf)
    );

    quad_mac_lane #(
        .SAMPLE_W(SAMPLE_W),
        .REF_W   (REF_W),
        .ACC_W   (ACC_W)
    ) u_quad (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr),
        .in_valid(accept),
        .sample  (bus.sample),
        .ref_val (bus.ref_sin),
        .acc     (quad_acc),
        .ovf     (quad_ovf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            n_lat  <= '0;
            cnt    <= '0;
            dcnt   <= '0;
            busy_r <= 1'b0;
            rv_r   <= 1'b0;
            pl_r   <= '0;
            ph_r   <= '0;
            ql_r   <= '0;
            qh_r   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_lat  <= bus.n_samples;
                        cnt    <= '0;
                        dcnt   <= '0;
                        busy_r <= 1'b1;
                        state  <= (bus.n_samples == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (bus.sample_valid) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == n_lat - CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                // last product lands in acc two edges after DRAIN entry
                DRAIN: begin
                    if (dcnt == 2'(DRAIN_CYCLES)) begin
                        state <= EMIT;
                        rv_r  <= 1'b1;
                        pl_r  <= phase_acc[31:0];
                        ph_r  <= phase_acc[63:32];
                        ql_r  <= quad_acc[31:0];
                        qh_r  <= quad_acc[63:32];
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                EMIT: begin
                    rv_r   <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy            = busy_r;
    assign bus.result_valid    = rv_r;
    assign bus.overflow        = phase_ovf | quad_ovf;
    assign bus.phase_low_data  = pl_r;
    assign bus.phase_high_data = ph_r;
    assign bus.quad_low_data   = ql_r;
    assign bus.quad_high_data  = qh_r;

endmodule
